wb_bus_env: RTL

//  N-channel Wishbone classic responder/monitor for formal and simulation harnesses around a CPU.

---
 rtl/wb_env_pkg.sv | 29 ++
 rtl/wb_bus_env_if.sv | 28 ++
 rtl/wb_env_channel.sv | 85 ++++++++
 rtl/wb_bus_env.sv | 73 +++++++
 4 files changed

// File: rtl/wb_env_pkg.sv
// Shared widths, FSM state encoding and the captured-request record used by
// the Wishbone responder/monitor environment.
package wb_env_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } wb_env_state_t;

    // Request fields a master must hold stable while it is being stalled.
    typedef struct packed {
        logic [WB_ADR_W-1:0] adr;
        logic [WB_SEL_W-1:0] sel;
        logic                we;
        logic [WB_DAT_W-1:0] dat_w;
    } wb_req_t;

    // True when the live request differs from the captured one; write data
    // only matters for writes.
    function automatic logic req_mismatch(input wb_req_t cap, input wb_req_t live);
        return (cap.adr != live.adr) || (cap.sel != live.sel) || (cap.we != live.we) ||
               (cap.we && (cap.dat_w != live.dat_w));
    endfunction

endpackage

// File: rtl/wb_bus_env_if.sv
// Packed N-channel Wishbone classic bus; channel 0 is the LSB slice.
interface wb_bus_env_if
    import wb_env_pkg::*;
#(
    parameter int NCH = 2
) ();

    logic [NCH*WB_ADR_W-1:0] adr;
    logic [NCH*WB_DAT_W-1:0] dat_w;
    logic [NCH*WB_SEL_W-1:0] sel;
    logic [NCH-1:0]          cyc;
    logic [NCH-1:0]          stb;
    logic [NCH-1:0]          we;
    logic [NCH*WB_DAT_W-1:0] dat_r;
    logic [NCH-1:0]          ack;
    logic [NCH-1:0]          err;

    modport master (
        output adr, dat_w, sel, cyc, stb, we,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, cyc, stb, we,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_env_channel.sv
// One responder channel: termination logic with a bounded stall, request
// capture while stalled, and a sticky protocol-violation checker.
// Optional error terminations are enabled by defining WB_ENV_ERR_EN.
module wb_env_channel
    import wb_env_pkg::*;
#(
    parameter int MAX_WAIT = 7
) (
    input  logic                clock,
    input  logic                reset,
    input  wb_req_t             live,
    input  logic                cyc,
    input  logic                stb,
    input  logic                rand_ack,
    input  logic                rand_err,
    input  logic [WB_DAT_W-1:0] rand_dat,
    output logic                ack,
    output logic                err,
    output logic [WB_DAT_W-1:0] dat_r,
    output logic                violation
);

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    wb_env_state_t    state;
    logic [CNT_W-1:0] wait_cnt;
    wb_req_t          cap;
    logic             req;
    logic             forced;
    logic             term;
    logic             rand_err_q;

`ifdef WB_ENV_ERR_EN
    assign rand_err_q = rand_err;
`else
    logic unused_rand_err;
    assign unused_rand_err = rand_err;
    assign rand_err_q      = 1'b0;
`endif

    assign req    = cyc & stb;
    assign forced = (wait_cnt == CNT_MAX);
    assign dat_r  = rand_dat;

    // Terminate a request on a free ack/err or once the stall budget is spent.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        term = 1'b0;
        ack  = 1'b0;
        err  = 1'b0;
        if (req) begin
            term = rand_ack | rand_err_q | forced;
            err  = term & rand_err_q;
            ack  = term & ~rand_err_q;
        end
    end

    // Stall FSM, wait counter and sticky violation flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: state is updated with <= so every flop samples the pre-edge values.
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            violation <= 1'b0;
        end else begin
            wait_cnt <= (req && !term) ? wait_cnt + CNT_W'(1) : '0;
            case (state)
                ST_IDLE: if (req && !term) state <= ST_WAIT;
                ST_WAIT: begin
                    if (!req || req_mismatch(cap, live)) violation <= 1'b1;
                    if (term || !req) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture the request that is about to stall.
    always_ff @(posedge clock) begin
        // NOTE: the capture register has no reset; it is only read in WAIT, which is entered by loading it.
        if (state == ST_IDLE && req && !term) cap <= live;
    end

endmodule

// File: rtl/wb_bus_env.sv
// N-channel Wishbone classic responder/monitor: per-channel responders plus
// packed rvfi_bus-style monitor vectors.
// Error terminations are enabled by defining WB_ENV_ERR_EN.
module wb_bus_env
    import wb_env_pkg::*;
#(
    parameter int             NCH       = 2,
    parameter int             MAX_WAIT  = 7,
    parameter logic [NCH-1:0] INSN_MASK = NCH'(2'b10)
) (
    input  logic                    clock,
    input  logic                    reset,
    wb_bus_env_if.slave             wb,
    input  logic [NCH-1:0]          rand_ack,
    input  logic [NCH-1:0]          rand_err,
    input  logic [NCH*WB_DAT_W-1:0] rand_dat,
    output logic [NCH-1:0]          mon_valid,
    output logic [NCH-1:0]          mon_insn,
    output logic [NCH-1:0]          mon_data,
    output logic [NCH-1:0]          mon_fault,
    output logic [NCH*32-1:0]       mon_addr,
    output logic [NCH*WB_SEL_W-1:0] mon_rmask,
    output logic [NCH*WB_SEL_W-1:0] mon_wmask,
    output logic [NCH*WB_DAT_W-1:0] mon_rdata,
    output logic [NCH*WB_DAT_W-1:0] mon_wdata,
    output logic [NCH-1:0]          violation
);

    logic [NCH-1:0]          ack_v;
    logic [NCH-1:0]          err_v;
    logic [NCH*WB_DAT_W-1:0] dat_r_v;

    assign wb.ack    = ack_v;
    assign wb.err    = err_v;
    assign wb.dat_r  = dat_r_v;
    assign mon_valid = wb.cyc & wb.stb;
    assign mon_insn  = INSN_MASK;
    assign mon_data  = ~INSN_MASK;
    assign mon_fault = err_v;
    assign mon_rdata = dat_r_v;
    assign mon_wdata = wb.dat_w;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        wb_req_t live;

        assign live.adr   = wb.adr[i*WB_ADR_W +: WB_ADR_W];
        assign live.sel   = wb.sel[i*WB_SEL_W +: WB_SEL_W];
        assign live.we    = wb.we[i];
        assign live.dat_w = wb.dat_w[i*WB_DAT_W +: WB_DAT_W];

        assign mon_addr[i*32 +: 32]             = {live.adr, 2'b00};
        assign mon_rmask[i*WB_SEL_W +: WB_SEL_W] = live.sel & {WB_SEL_W{~live.we}};
        assign mon_wmask[i*WB_SEL_W +: WB_SEL_W] = live.sel & {WB_SEL_W{live.we}};

        wb_env_channel #(
            .MAX_WAIT(MAX_WAIT)
        ) u_channel (
            .clock    (clock),
            .reset    (reset),
            .live     (live),
            .cyc      (wb.cyc[i]),
            .stb      (wb.stb[i]),
            .rand_ack (rand_ack[i]),
            .rand_err (rand_err[i]),
            .rand_dat (rand_dat[i*WB_DAT_W +: WB_DAT_W]),
            .ack      (ack_v[i]),
            .err      (err_v[i]),
            .dat_r    (dat_r_v[i*WB_DAT_W +: WB_DAT_W]),
            .violation(violation[i])
        );
    end

endmodule
